// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and the divide-by-zero fill value for the ALU
// command issuer and its testbench.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Wide enough for any WIDTH; users slice the low WIDTH bits.
  localparam logic [63:0] DIV0_FILL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic is_div0(input logic [1:0] op, input logic b_is_zero);
    return (op == OP_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Request, ALU drive and response signals of the ALU command issuer.
// Both channels use valid/ready: a transfer happens on every rising edge where
// VALID and READY are both high; a source holds VALID and payload until then.
interface alu_cmd_issuer_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  import alu_pkg::*;

  logic                 REQ_VALID;
  logic                 REQ_READY;
  logic [1:0]           REQ_OP;
  logic [WIDTH-1:0]     REQ_A;
  logic [WIDTH-1:0]     REQ_B;
  logic [1:0]           ALU_OPERATION;
  logic [WIDTH-1:0]     ALU_OPERAND1;
  logic [WIDTH-1:0]     ALU_OPERAND2;
  logic [WIDTH-1:0]     ALU_RESULT;
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [WIDTH-1:0]     RSP_DATA;
  logic                 RSP_DIV0;
  logic [1:0]           RSP_OP;
  logic                 BUSY;
  logic [CNT_WIDTH-1:0] OP_COUNT;
  state_t               DBG_STATE;

  // slave: the issuer itself; master: the sequencer plus the ALU beside it.
  modport slave (
    input  REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    output REQ_READY, ALU_OPERATION, ALU_OPERAND1, ALU_OPERAND2,
           RSP_VALID, RSP_DATA, RSP_DIV0, RSP_OP, BUSY, OP_COUNT, DBG_STATE
  );

  modport master (
    output REQ_VALID, REQ_OP, REQ_A, REQ_B, ALU_RESULT, RSP_READY,
    input  REQ_READY, ALU_OPERATION, ALU_OPERAND1, ALU_OPERAND2,
           RSP_VALID, RSP_DATA, RSP_DIV0, RSP_OP, BUSY, OP_COUNT, DBG_STATE
  );

endinterface

// File: rtl/alu_settle_timer.sv
// Loadable down-counter that times how long the ALU inputs have been held.
// It stops at zero and flags it.
module alu_settle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for a combinational ALU: latches a request onto the ALU inputs,
// waits SETTLE_CYCLES, captures RESULT and offers it on the response channel.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input logic              CLK,
  input logic              RST,
  alu_cmd_issuer_if.slave  bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 accept, capture, rsp_hs, settle_zero;
  logic [1:0]           alu_op_q, rsp_op_q;
  logic [WIDTH-1:0]     a_q, b_q, rsp_data_q;
  logic                 div0_q, rsp_div0_q;
  logic [CNT_WIDTH-1:0] op_count_q;

  // Readiness is a pure function of state so REQ_READY never depends on REQ_VALID.
  assign accept  = (state_q == ST_IDLE) && bus.REQ_VALID;
  assign capture = (state_q == ST_DRIVE) && settle_zero;
  assign rsp_hs  = (state_q == ST_RESP) && bus.RSP_READY;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)  state_d = ST_DRIVE;
      ST_DRIVE: if (capture) state_d = ST_RESP;
      ST_RESP:  if (rsp_hs)  state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  alu_settle_timer #(.CW(4)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .en       (state_q == ST_DRIVE),
    .zero     (settle_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_op_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_op_q   <= '0;
      div0_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_div0_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        alu_op_q <= bus.REQ_OP;
        a_q      <= bus.REQ_A;
        b_q      <= bus.REQ_B;
        rsp_op_q <= bus.REQ_OP;
        div0_q   <= is_div0(bus.REQ_OP, bus.REQ_B == '0);
      end
      // Divide-by-zero overrides whatever the ALU produced.
      if (capture) begin
        rsp_data_q <= div0_q ? DIV0_FILL[WIDTH-1:0] : bus.ALU_RESULT;
        rsp_div0_q <= div0_q;
      end
      if (rsp_hs) op_count_q <= op_count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.REQ_READY     = (state_q == ST_IDLE);
  assign bus.RSP_VALID     = (state_q == ST_RESP);
  assign bus.BUSY          = (state_q != ST_IDLE);
  assign bus.ALU_OPERATION = alu_op_q;
  assign bus.ALU_OPERAND1  = a_q;
  assign bus.ALU_OPERAND2  = b_q;
  assign bus.RSP_DATA      = rsp_data_q;
  assign bus.RSP_DIV0      = rsp_div0_q;
  assign bus.RSP_OP        = rsp_op_q;
  assign bus.OP_COUNT      = op_count_q;
  assign bus.DBG_STATE     = state_q;

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the 8-bit ALU operation interface. Accepts operation requests on a valid/ready channel and drives the ALU's OPERATION/OPERAND1/OPERAND2 inputs. Holds those inputs for a programmable settle time, then captures RESULT and returns it on a valid/ready response channel. Sits between a sequencer/CPU datapath and the combinational ALU; also traps divide-by-zero.

Parameters:
WIDTH, 8, operand/result width in bits
SETTLE_CYCLES, 1, cycles ALU inputs are held before RESULT is captured (legal range 1..15)
CNT_WIDTH, 16, width of the completed-operation counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
REQ_VALID  input  1  request valid
REQ_READY  output  1  request ready
REQ_OP  input  2  0:ADD 1:SUB 2:MUL 3:DIV
REQ_A  input  WIDTH  operand 1
REQ_B  input  WIDTH  operand 2
ALU_OPERATION  output  2  to ALU OPERATION
ALU_OPERAND1  output  WIDTH  to ALU OPERAND1
ALU_OPERAND2  output  WIDTH  to ALU OPERAND2
ALU_RESULT  input  WIDTH  from ALU RESULT
RSP_VALID  output  1  response valid
RSP_READY  input  1  response ready
RSP_DATA  output  WIDTH  captured result
RSP_DIV0  output  1  divide-by-zero flag
RSP_OP  output  2  opcode of this response
BUSY  output  1  high whenever state != IDLE
OP_COUNT  output  CNT_WIDTH  completed responses, wraps

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE; every output register is 0 (ALU_*, RSP_*, OP_COUNT); settle counter=0. REQ_READY=1 in the cycle after reset.
- Reset mid-operation: any in-flight request or pending response is dropped silently and OP_COUNT is not incremented.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: REQ_READY=1. Decoded from state only, never from REQ_VALID.
  - On a REQ_VALID && REQ_READY edge, REQ_OP/A/B are registered onto the ALU_* ports and into RSP_OP.
  - At the same edge: settle counter loads SETTLE_CYCLES-1, div0 flag latches (REQ_OP==3 && REQ_B==0), and state goes to DRIVE.
  - REQ_* fields are sampled only on that handshake edge.
- DRIVE: REQ_READY=0 and ALU_* held constant.
  - While the counter != 0, it decrements each cycle.
  - On the edge with counter==0: RSP_DATA loads ALU_RESULT, or all-ones when div0. RSP_DIV0 loads div0 and state goes to RESP.
- Latency: RSP_VALID rises exactly SETTLE_CYCLES edges after the accept edge. Divide-by-zero has the same latency.
- RESP: RSP_VALID=1. RSP_DATA/DIV0/OP stay stable while RSP_READY=0, with no cycle limit.
  - On the RSP_VALID && RSP_READY edge: OP_COUNT increments modulo 2^CNT_WIDTH and state goes to IDLE.
  - RSP_VALID=0 from the next cycle; RSP_DATA keeps its last value.
- No overlap: a new request is accepted no earlier than the cycle after the response handshake. Peak throughput is 1 op per SETTLE_CYCLES+2 cycles.
- ALU_* outputs keep their last values in IDLE and do not toggle without a request.
- Arithmetic: width and truncation rules belong to the ALU; the issuer passes the low WIDTH bits through unmodified. MUL is modulo 2^WIDTH, SUB wraps, DIV is unsigned floor. The only override is the div0 fill.
- REQ_VALID asserted outside IDLE is ignored, not queued. The requester must hold it under standard valid/ready rules.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DIV=2'd3
  - FSM state encoding
  - the DIV0_FILL constant (all ones)
- One sub-module is natural: alu_settle_timer, a loadable down-counter with a zero flag.
- The ALU itself is instantiated beside this block at the parent level, not inside it.

Test Plan:
1. SETTLE=1, ADD A=2 B=2, RSP_READY=1 -> REQ_READY low one cycle after accept; RSP_VALID high 1 edge after accept with DATA=0x04, DIV0=0, OP=0; OP_COUNT=1.
2. Back-to-back SUB 2-5, MUL 20*20, DIV 7/2 -> DATA 0xFD, 0x90, 0x03; accept spacing exactly SETTLE+2 cycles; OP_COUNT=3.
3. DIV 9/0 -> DATA=0xFF, DIV0=1, same latency as DIV 9/3 (DATA=0x03, DIV0=0).
4. SETTLE=4, RSP_READY low 6 cycles with REQ_VALID held high -> RSP_VALID at accept+4 edges; payload stable; REQ_READY stays 0; second request accepted only after the response handshake.
5. SETTLE=4, RST pulsed at the 2nd DRIVE cycle -> next cycle all outputs 0, state IDLE, no RSP_VALID, OP_COUNT=0.
6. CNT_WIDTH=2, five completed ops -> OP_COUNT sequence 1,2,3,0,1; BUSY matches non-IDLE cycles exactly.
